ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_sync_edge.sv | 27 ++
 rtl/ps2_host_tx.sv | 166 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, frame bit indices
// and default timing at a 50 MHz system clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int BIT_W = 4;
  localparam logic [BIT_W-1:0] BIT_PAR  = 4'd8;
  localparam logic [BIT_W-1:0] BIT_STOP = 4'd9;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;     // 100 us
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;  // 20 ms

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge pulse on the
// synchronized level. Everything resets to the idle (high) line level.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= 1'b1;
      line_sync <= 1'b1;
      prev      <= 1'b1;
    end else begin
      meta      <= line_in;
      line_sync <= meta;
      prev      <= line_sync;
    end
  end

  assign fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain line enables.
// Define PS2_HOST_TX_TIMEOUT_EN to add a transfer watchdog that aborts a stalled transfer.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);

  state_t           state, state_n;
  logic [ICW-1:0]   cnt, cnt_n;
  logic [BIT_W-1:0] bitcnt, bit_n;
  logic [7:0]       data_q, data_n;
  logic             clk_oe_n, data_oe_n, busy_n, ready_n, done_n, err_n;
  logic             clk_s, clk_fall, dat_s, unused_dat_fall;

  ps2_sync_edge u_sync_clk (
    .clk(clk), .rst(rst), .line_in(ps2_clk_in), .line_sync(clk_s), .fall(clk_fall)
  );
  ps2_sync_edge u_sync_dat (
    .clk(clk), .rst(rst), .line_in(ps2_data_in), .line_sync(dat_s), .fall(unused_dat_fall)
  );

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd, wd_n;
  logic          to_n;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bitcnt;
    data_n    = data_q;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    busy_n    = busy;
    ready_n   = tx_ready;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_n   = INHIBIT;
        data_n    = tx_data;
        cnt_n     = '0;
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        busy_n    = 1'b1;
        ready_n   = 1'b0;
      end
      // cnt 0..N-1: clock held low alone; cnt N: clock and data both low
      INHIBIT: if (cnt == ICW'(INHIBIT_CYCLES)) begin
        state_n   = START;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
        if (cnt == ICW'(INHIBIT_CYCLES - 1)) data_oe_n = 1'b1;
      end
      START: begin
        state_n = XFER;
        bit_n   = '0;
      end
      XFER: if (clk_fall) begin
        bit_n = bitcnt + 1'b1;
        if (bitcnt == BIT_STOP) begin
          data_oe_n = 1'b0;
          state_n   = ACK;
        end else if (bitcnt == BIT_PAR) begin
          data_oe_n = ~odd_parity(data_q);
        end else begin
          data_oe_n = ~data_q[bitcnt[2:0]];
        end
      end
      ACK: if (clk_fall) begin
        state_n = WAIT_IDLE;
        if (!dat_s) done_n = 1'b1;
        else        err_n  = 1'b1;
      end
      WAIT_IDLE: if (clk_s && dat_s) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    wd_n = wd;
    to_n = 1'b0;
    if (state == INHIBIT) begin
      wd_n = '0;
    end else if (state == START || state == XFER || state == ACK) begin
      if (wd == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n   = IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        busy_n    = 1'b0;
        ready_n   = 1'b1;
        done_n    = 1'b0;
        err_n     = 1'b0;
        to_n      = 1'b1;
      end else begin
        wd_n = wd + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      data_q      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      done        <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bitcnt      <= bit_n;
      data_q      <= data_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      tx_ready    <= ready_n;
      done        <= done_n;
      ack_err     <= err_n;
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      wd      <= wd_n;
      timeout <= to_n;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of bytes/ack behaviour driven through
// a PS/2 device model, with expected frame bits queued per byte and popped as sampled.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TMO = 10000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  typedef struct {
    logic [7:0] d;
    logic       ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  int   n_vec = 0, n_err = 0;
  int   done_cnt = 0, err_cnt = 0, to_cnt = 0;
  logic exp_q[$];

  always @(negedge clk) begin
    if (done)    done_cnt++;
    if (ack_err) err_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input bit hold, input logic [7:0] nxt);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20000);
    chk("accept", busy, 1);
    chk("ready_low", tx_ready, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
    if (hold) tx_data = nxt;
    else      tx_valid = 1'b0;
  endtask

  task automatic inhibit_chk();
    int a = 0, b = 0;
    while (ps2_clk_oe && !ps2_data_oe && a < 20000) begin
      a++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && b < 10) begin
      b++;
      @(negedge clk);
    end
    chk("inhibit_len", a, INH);
    chk("both_low_len", b, 1);
    chk("start_clk_oe", ps2_clk_oe, 0);
    chk("start_data_oe", ps2_data_oe, 1);
  endtask

  task automatic dev_xfer(input int nb, input logic ack);
    logic got, e;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      got = ~(ps2_data_oe | dev_data_low);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("frame_bit%0d", i), got, e);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_empty: bit %0d sampled %0d with nothing expected", i, got);
      end
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    if (nb == 10) begin
      dev_data_low = ack;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_falls", busy, 0);
  endtask

  vec_t vecs[5];
  int   d0, e0, t0, n;

  initial begin
    vecs[0] = '{8'hED, 1'b1, 1, 0};
    vecs[1] = '{8'hF4, 1'b1, 1, 0};
    vecs[2] = '{8'hA5, 1'b0, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_pulses", done | ack_err | timeout, 0);

    foreach (vecs[k]) begin
      d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
      start_tx(vecs[k].d, 1'b0, 8'h00);
      inhibit_chk();
      dev_xfer(10, vecs[k].ack);
      wait_idle();
      chk($sformatf("v%0d_done", k), done_cnt - d0, vecs[k].exp_done);
      chk($sformatf("v%0d_ack_err", k), err_cnt - e0, vecs[k].exp_err);
      chk($sformatf("v%0d_timeout", k), to_cnt - t0, 0);
      chk($sformatf("v%0d_ready", k), tx_ready, 1);
      chk($sformatf("v%0d_lines", k), {ps2_clk_oe, ps2_data_oe}, 0);
      repeat (5) @(negedge clk);
    end

    // tx_valid held through a transfer: the new byte waits for the first to finish
    d0 = done_cnt;
    start_tx(8'hED, 1'b1, 8'h55);
    inhibit_chk();
    dev_xfer(10, 1'b1);
    wait_idle();
    chk("held_done_first", done_cnt - d0, 1);
    chk("held_q_drained", exp_q.size(), 0);
    start_tx(8'h55, 1'b0, 8'h00);
    inhibit_chk();
    dev_xfer(10, 1'b1);
    wait_idle();
    chk("held_done_second", done_cnt - d0, 2);

    // reset in the middle of the frame, while bit 4 is on the line
    start_tx(8'h3C, 1'b0, 8'h00);
    inhibit_chk();
    dev_xfer(5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_data_oe", ps2_data_oe, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);

    // device never clocks
    d0 = done_cnt; t0 = to_cnt;
    start_tx(8'h12, 1'b0, 8'h00);
    inhibit_chk();
`ifdef PS2_HOST_TX_TIMEOUT_EN
    n = 0;
    while (!timeout && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_at", n, TMO);
    chk("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    chk("timeout_once", to_cnt - t0, 1);
`else
    repeat (TMO + 2000) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_ready", tx_ready, 0);
    chk("stall_timeout", to_cnt - t0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    chk("stall_no_done", done_cnt - d0, 0);
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
